// File: rtl/apb_slave_if.sv
// APB completer interface. Decodes an APB transfer against an address window and
// forwards it to a backend over a sel/ready handshake. The APB response is
// registered. An error response is returned on a decode miss, a protection
// violation, a backend error, a backend timeout, or a bus change mid-transfer.
//
// Ports:
//   apb_clk_in, apb_rstn_in  clock, asynchronous active-low reset
//   apb_*_in                 APB requester signals (PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB/PPROT)
//   apb_*_out                APB response (PRDATA/PREADY/PSLVERR)
//   other_*_out              backend request: address offset, sel, direction, data, strobes, prot
//   other_*_in               backend response: read data, ready, error (valid with ready)
module apb_slave_if #(
    parameter int unsigned                 APB_DATA_WIDTH = 32,
    parameter int unsigned                 APB_ADDR_WIDTH = 32,
    parameter logic [APB_ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
    parameter logic [APB_ADDR_WIDTH:0]     ADDR_RANGE     = 'h1000,
    parameter int unsigned                 TIMEOUT_CYCLE  = 6,
    parameter bit                          SECURE_ONLY    = 1'b0
) (
    input  logic                          apb_clk_in,
    input  logic                          apb_rstn_in,
    input  logic [APB_ADDR_WIDTH-1:0]     apb_addr_in,
    input  logic                          apb_psel_in,
    input  logic                          apb_penable_in,
    input  logic                          apb_write_in,
    input  logic [APB_DATA_WIDTH-1:0]     apb_wdata_in,
    input  logic [APB_DATA_WIDTH/8-1:0]   apb_strb_in,
    input  logic [2:0]                    apb_prot_in,
    output logic [APB_DATA_WIDTH-1:0]     apb_rdata_out,
    output logic                          apb_ready_out,
    output logic                          apb_slverr_out,
    output logic [APB_ADDR_WIDTH-1:0]     other_addr_out,
    output logic                          other_sel_out,
    output logic                          other_write_out,
    output logic [APB_DATA_WIDTH-1:0]     other_wdata_out,
    output logic [APB_DATA_WIDTH/8-1:0]   other_strb_out,
    output logic [2:0]                    other_prot_out,
    input  logic [APB_DATA_WIDTH-1:0]     other_rdata_in,
    input  logic                          other_ready_in,
    input  logic                          other_error_in
);

    localparam int unsigned StrbW = APB_DATA_WIDTH / 8;
    localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLE + 1);
    // One extra bit so the window end never wraps.
    localparam logic [APB_ADDR_WIDTH:0] WinLo = {1'b0, BASE_ADDR};
    localparam logic [APB_ADDR_WIDTH:0] WinHi = WinLo + ADDR_RANGE;

    typedef enum logic [3:0] {
        StIdle = 4'b0001,
        StReq  = 4'b0010,
        StResp = 4'b0100,
        StErr  = 4'b1000
    } state_e;

    state_e                     state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0]  addr_q, addr_d;    // offset from BASE_ADDR
    logic                       write_q, write_d;
    logic [APB_DATA_WIDTH-1:0]  wdata_q, wdata_d;  // raw PWDATA, masked on output for reads
    logic [StrbW-1:0]           strb_q, strb_d;
    logic [2:0]                 prot_q, prot_d;
    logic                       sel_q, sel_d;
    logic                       ready_q, ready_d;
    logic                       slverr_q, slverr_d;
    logic [APB_DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [CntW-1:0]            cnt_q, cnt_d;

    logic [APB_ADDR_WIDTH:0]    addr_ext;
    logic [APB_ADDR_WIDTH-1:0]  addr_off;
    logic [CntW-1:0]            cnt_inc;
    logic                       hit;
    logic                       prot_bad;
    logic                       bus_changed;

    always_comb begin
        addr_ext    = {1'b0, apb_addr_in};
        addr_off    = apb_addr_in - BASE_ADDR;
        hit         = (addr_ext >= WinLo) && (addr_ext < WinHi);
        prot_bad    = SECURE_ONLY && apb_prot_in[1];
        cnt_inc     = cnt_q + CntW'(1);
        bus_changed = (addr_off != addr_q) || (apb_write_in != write_q) ||
                      (apb_prot_in != prot_q) || (apb_strb_in != strb_q) ||
                      (write_q && (apb_wdata_in != wdata_q));
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        prot_d   = prot_q;
        cnt_d    = cnt_q;
        sel_d    = 1'b0;
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        rdata_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (apb_psel_in && !apb_penable_in) begin
                    addr_d  = addr_off;
                    write_d = apb_write_in;
                    wdata_d = apb_wdata_in;
                    strb_d  = apb_strb_in;
                    prot_d  = apb_prot_in;
                    if (!hit || prot_bad) begin
                        state_d  = StErr;
                        ready_d  = 1'b1;
                        slverr_d = 1'b1;
                    end else begin
                        state_d = StReq;
                        sel_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end else if (apb_psel_in && apb_penable_in) begin
                    // Access phase with no setup phase seen.
                    state_d  = StErr;
                    ready_d  = 1'b1;
                    slverr_d = 1'b1;
                end
            end
            StReq: begin
                sel_d = 1'b1;
                if (!apb_psel_in) begin
                    // Requester abandoned the transfer: no response.
                    state_d = StIdle;
                    sel_d   = 1'b0;
                end else if (bus_changed) begin
                    state_d  = StErr;
                    sel_d    = 1'b0;
                    ready_d  = 1'b1;
                    slverr_d = 1'b1;
                end else if (other_ready_in) begin
                    state_d  = StResp;
                    sel_d    = 1'b0;
                    ready_d  = 1'b1;
                    slverr_d = other_error_in;
                    rdata_d  = write_q ? '0 : other_rdata_in;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntW'(TIMEOUT_CYCLE)) begin
                        state_d  = StErr;
                        sel_d    = 1'b0;
                        ready_d  = 1'b1;
                        slverr_d = 1'b1;
                    end
                end
            end
            StResp, StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prot_q   <= '0;
            sel_q    <= 1'b0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            prot_q   <= prot_d;
            sel_q    <= sel_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        apb_rdata_out   = rdata_q;
        apb_ready_out   = ready_q;
        apb_slverr_out  = slverr_q;
        other_addr_out  = addr_q;
        other_sel_out   = sel_q;
        other_write_out = write_q;
        other_wdata_out = write_q ? wdata_q : '0;
        other_strb_out  = write_q ? strb_q : '0;
        other_prot_out  = prot_q;
    end

endmodule

// File: tb/tb_apb_slave_if.sv
// Scoreboard bench for apb_slave_if. Each transfer pushes its expected APB
// response; a monitor pops and compares whenever PREADY is seen. Backend-side
// behaviour (sel duration, offset, strobes, data) and latency are checked per transfer.
module tb_apb_slave_if;

    localparam logic [31:0] Base = 32'h0000_2000;

    logic        apb_clk_in;
    logic        apb_rstn_in;
    logic [31:0] apb_addr_in;
    logic        apb_psel_in;
    logic        apb_penable_in;
    logic        apb_write_in;
    logic [31:0] apb_wdata_in;
    logic [3:0]  apb_strb_in;
    logic [2:0]  apb_prot_in;
    logic [31:0] apb_rdata_out;
    logic        apb_ready_out;
    logic        apb_slverr_out;
    logic [31:0] other_addr_out;
    logic        other_sel_out;
    logic        other_write_out;
    logic [31:0] other_wdata_out;
    logic [3:0]  other_strb_out;
    logic [2:0]  other_prot_out;
    logic [31:0] other_rdata_in;
    logic        other_ready_in;
    logic        other_error_in;

    apb_slave_if #(
        .APB_DATA_WIDTH (32),
        .APB_ADDR_WIDTH (32),
        .BASE_ADDR      (Base),
        .ADDR_RANGE     (33'h1000),
        .TIMEOUT_CYCLE  (6),
        .SECURE_ONLY    (1'b1)
    ) dut (
        .apb_clk_in      (apb_clk_in),
        .apb_rstn_in     (apb_rstn_in),
        .apb_addr_in     (apb_addr_in),
        .apb_psel_in     (apb_psel_in),
        .apb_penable_in  (apb_penable_in),
        .apb_write_in    (apb_write_in),
        .apb_wdata_in    (apb_wdata_in),
        .apb_strb_in     (apb_strb_in),
        .apb_prot_in     (apb_prot_in),
        .apb_rdata_out   (apb_rdata_out),
        .apb_ready_out   (apb_ready_out),
        .apb_slverr_out  (apb_slverr_out),
        .other_addr_out  (other_addr_out),
        .other_sel_out   (other_sel_out),
        .other_write_out (other_write_out),
        .other_wdata_out (other_wdata_out),
        .other_strb_out  (other_strb_out),
        .other_prot_out  (other_prot_out),
        .other_rdata_in  (other_rdata_in),
        .other_ready_in  (other_ready_in),
        .other_error_in  (other_error_in)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
    } resp_t;

    resp_t exp_q[$];
    int    n_run  = 0;
    int    n_fail = 0;

    // Backend behaviour: ready after bk_wait sel cycles; negative means never.
    int          bk_wait  = -1;
    logic [31:0] bk_rdata = '0;
    logic        bk_err   = 1'b0;

    initial apb_clk_in = 1'b0;
    always #5 apb_clk_in = ~apb_clk_in;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endfunction

    // Backend model.
    initial begin : backend
        int waited;
        waited         = 0;
        other_ready_in = 1'b0;
        other_rdata_in = '0;
        other_error_in = 1'b0;
        forever begin
            @(posedge apb_clk_in);
            #1;
            other_ready_in = 1'b0;
            other_rdata_in = '0;
            other_error_in = 1'b0;
            if (other_sel_out) begin
                if (bk_wait >= 0 && waited == bk_wait) begin
                    other_ready_in = 1'b1;
                    other_rdata_in = bk_rdata;
                    other_error_in = bk_err;
                    waited         = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    // Response monitor.
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge apb_clk_in);
            if (apb_ready_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pready", 32'(apb_ready_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("prdata", apb_rdata_out, e.rdata);
                    check("pslverr", 32'(apb_slverr_out), 32'(e.slverr));
                end
            end
        end
    end

    // One APB transfer. exp_sel: cycles other_sel_out is seen high; exp_acc:
    // access-phase cycles up to and including the PREADY cycle.
    task automatic apb_xfer(input string name, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [2:0] prot, input logic chg_addr, input int wait_n,
                            input logic [31:0] rd, input logic err,
                            input logic [31:0] exp_rdata, input logic exp_slverr,
                            input int exp_sel, input int exp_acc,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        int          acc;
        int          sel_n;
        logic        got;
        logic [31:0] seen_off;
        logic [3:0]  seen_strb;
        logic [31:0] seen_wdata;
        bk_wait  = wait_n;
        bk_rdata = rd;
        bk_err   = err;
        exp_q.push_back('{rdata: exp_rdata, slverr: exp_slverr});
        @(posedge apb_clk_in);
        #1;
        apb_psel_in    = 1'b1;
        apb_penable_in = 1'b0;
        apb_write_in   = wr;
        apb_addr_in    = addr;
        apb_wdata_in   = wdata;
        apb_strb_in    = strb;
        apb_prot_in    = prot;
        @(posedge apb_clk_in);
        #1;
        apb_penable_in = 1'b1;
        if (chg_addr) apb_addr_in = addr ^ 32'h4;
        acc        = 0;
        sel_n      = 0;
        got        = 1'b0;
        seen_off   = '0;
        seen_strb  = '0;
        seen_wdata = '0;
        while (!got && acc < 40) begin
            @(negedge apb_clk_in);
            acc++;
            if (other_sel_out) begin
                sel_n++;
                seen_off   = other_addr_out;
                seen_strb  = other_strb_out;
                seen_wdata = other_wdata_out;
            end
            if (apb_ready_out) got = 1'b1;
        end
        if (!got) begin
            void'(exp_q.pop_back());
            check({name, "_pready_timeout"}, 32'(got), 32'd1);
        end
        check({name, "_sel_cycles"}, 32'(sel_n), 32'(exp_sel));
        check({name, "_access_cycles"}, 32'(acc), 32'(exp_acc));
        if (exp_sel > 0) begin
            check({name, "_offset"}, seen_off, addr - Base);
            check({name, "_strb"}, 32'(seen_strb), 32'(exp_strb));
            check({name, "_wdata"}, seen_wdata, exp_wdata);
        end
        @(posedge apb_clk_in);
        #1;
        apb_psel_in    = 1'b0;
        apb_penable_in = 1'b0;
    endtask

    initial begin : stimulus
        int waits;
        apb_rstn_in    = 1'b0;
        apb_addr_in    = '0;
        apb_psel_in    = 1'b0;
        apb_penable_in = 1'b0;
        apb_write_in   = 1'b0;
        apb_wdata_in   = '0;
        apb_strb_in    = '0;
        apb_prot_in    = '0;
        repeat (2) @(posedge apb_clk_in);
        #1;
        apb_rstn_in = 1'b1;
        @(negedge apb_clk_in);
        check("rst_pready", 32'(apb_ready_out), 32'd0);
        check("rst_pslverr", 32'(apb_slverr_out), 32'd0);
        check("rst_prdata", apb_rdata_out, 32'd0);
        check("rst_sel", 32'(other_sel_out), 32'd0);
        check("rst_addr", other_addr_out, 32'd0);
        check("rst_strb", 32'(other_strb_out), 32'd0);

        // name, wr, addr, wdata, strb, prot, chg, wait, rd, err, exp_rd, exp_err, sel, acc, strb, wdata
        apb_xfer("wr_fast", 1'b1, Base + 32'h10, 32'hA5A5_5A5A, 4'hF, 3'b000, 1'b0, 0,
                 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1, 2, 4'hF, 32'hA5A5_5A5A);
        apb_xfer("rd_wait2", 1'b0, Base + 32'h4, 32'h1111_2222, 4'hF, 3'b000, 1'b0, 2,
                 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 3, 4, 4'h0, 32'h0);
        apb_xfer("rd_miss_hi", 1'b0, Base + 32'h1000, 32'h0, 4'h0, 3'b000, 1'b0, 0,
                 32'h5555_5555, 1'b0, 32'h0, 1'b1, 0, 1, 4'h0, 32'h0);
        apb_xfer("rd_miss_lo", 1'b0, Base - 32'h4, 32'h0, 4'h0, 3'b000, 1'b0, 0,
                 32'h5555_5555, 1'b0, 32'h0, 1'b1, 0, 1, 4'h0, 32'h0);
        apb_xfer("rd_last_bkerr", 1'b0, Base + 32'hFFC, 32'h0, 4'h0, 3'b000, 1'b0, 0,
                 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1, 2, 4'h0, 32'h0);
        apb_xfer("wr_timeout", 1'b1, Base + 32'h20, 32'h0F0F_0F0F, 4'h3, 3'b000, 1'b0, -1,
                 32'h0, 1'b0, 32'h0, 1'b1, 6, 7, 4'h3, 32'h0F0F_0F0F);
        apb_xfer("rd_ready_at_limit", 1'b0, Base + 32'h30, 32'h0, 4'h0, 3'b000, 1'b0, 5,
                 32'h7777_8888, 1'b0, 32'h7777_8888, 1'b0, 6, 7, 4'h0, 32'h0);
        apb_xfer("wr_nonsecure", 1'b1, Base + 32'h10, 32'h1234_0000, 4'hF, 3'b010, 1'b0, 0,
                 32'h0, 1'b0, 32'h0, 1'b1, 0, 1, 4'h0, 32'h0);
        apb_xfer("rd_priv_secure", 1'b0, Base + 32'h44, 32'h0, 4'h0, 3'b001, 1'b0, 1,
                 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 2, 3, 4'h0, 32'h0);
        apb_xfer("rd_addr_change", 1'b0, Base + 32'h8, 32'h0, 4'h0, 3'b000, 1'b1, -1,
                 32'h0, 1'b0, 32'h0, 1'b1, 1, 2, 4'h0, 32'h0);

        // Reset in the middle of a backend request: no response may follow.
        bk_wait = -1;
        @(posedge apb_clk_in);
        #1;
        apb_psel_in    = 1'b1;
        apb_penable_in = 1'b0;
        apb_write_in   = 1'b0;
        apb_addr_in    = Base + 32'h40;
        apb_strb_in    = 4'h0;
        apb_prot_in    = 3'b000;
        @(posedge apb_clk_in);
        #1;
        apb_penable_in = 1'b1;
        waits = 0;
        while (!other_sel_out && waits < 5) begin
            @(negedge apb_clk_in);
            waits++;
        end
        @(negedge apb_clk_in);
        check("rst_mid_sel_before", 32'(other_sel_out), 32'd1);
        apb_rstn_in = 1'b0;
        #1;
        check("rst_mid_sel", 32'(other_sel_out), 32'd0);
        check("rst_mid_pready", 32'(apb_ready_out), 32'd0);
        @(posedge apb_clk_in);
        #1;
        apb_psel_in    = 1'b0;
        apb_penable_in = 1'b0;
        @(posedge apb_clk_in);
        #1;
        apb_rstn_in = 1'b1;

        apb_xfer("rd_after_rst", 1'b0, Base + 32'h40, 32'h0, 4'h0, 3'b000, 1'b0, 0,
                 32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE, 1'b0, 1, 2, 4'h0, 32'h0);

        repeat (3) @(negedge apb_clk_in);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave_if.md
Name: apb_slave_if

Overview:
APB completer (slave) interface. It is the responder counterpart of the team's APB master interface. It decodes an APB transfer against its own address window, then forwards it to a backend module over a simple sel/ready handshake. It returns PRDATA/PREADY/PSLVERR to the bus and generates an error response on decode failure, protection violation, backend error, timeout or a mid-transfer bus change.

Parameters:
APB_DATA_WIDTH, 32, data bus width; must be a multiple of 8.
APB_ADDR_WIDTH, 32, address bus width.
BASE_ADDR, 0, first byte address of the window.
ADDR_RANGE, 'h1000, window size in bytes; an address hits when BASE_ADDR <= addr < BASE_ADDR+ADDR_RANGE.
TIMEOUT_CYCLE, 6, maximum number of backend wait cycles before an error response.
SECURE_ONLY, 0, when 1 any access with prot[1]=1 (non-secure) is rejected.

Ports:
apb_clk_in  input  1  APB clock
apb_rstn_in  input  1  asynchronous active-low reset
apb_addr_in  input  APB_ADDR_WIDTH  PADDR
apb_psel_in  input  1  PSEL
apb_penable_in  input  1  PENABLE
apb_write_in  input  1  PWRITE
apb_wdata_in  input  APB_DATA_WIDTH  PWDATA
apb_strb_in  input  APB_DATA_WIDTH/8  PSTRB
apb_prot_in  input  3  PPROT
apb_rdata_out  output  APB_DATA_WIDTH  PRDATA
apb_ready_out  output  1  PREADY
apb_slverr_out  output  1  PSLVERR
other_addr_out  output  APB_ADDR_WIDTH  address offset (addr - BASE_ADDR)
other_sel_out  output  1  backend request, held until ready or abort
other_write_out  output  1  backend direction
other_wdata_out  output  APB_DATA_WIDTH  backend write data
other_strb_out  output  APB_DATA_WIDTH/8  backend byte strobes
other_prot_out  output  3  forwarded protection
other_rdata_in  input  APB_DATA_WIDTH  backend read data
other_ready_in  input  1  backend completion
other_error_in  input  1  backend error, valid with other_ready_in

Behaviour:
- Reset is apb_rstn_in, asynchronous, active-low. Clock is apb_clk_in. All logic is posedge. Every output register resets to 0, wait counter resets to 0, state resets to IDLE.
- A reset asserted mid-transfer drops other_sel_out and apb_ready_out immediately. No response is issued.
- The FSM is one-hot with states IDLE, REQ, RESP and ERR.
- IDLE:
  - Outputs: apb_ready_out=0, other_sel_out=0.
  - Setup phase (psel=1, penable=0) sampled at a posedge: latch addr, write, wdata, strb and prot.
  - If the address misses the window, or SECURE_ONLY=1 and prot[1]=1: go to ERR. The backend is never selected.
  - Otherwise go to REQ with other_sel_out=1 and other_addr_out=addr-BASE_ADDR.
  - On reads, other_wdata_out=0 and other_strb_out=0, whatever PSTRB is.
  - psel=1 with penable=1 seen in IDLE is a protocol error: go to ERR.
- REQ:
  - Hold all other_* outputs stable. The counter increments each cycle other_ready_in=0.
  - other_ready_in=1: capture other_rdata_in (forced to 0 on writes) and other_error_in, drop other_sel_out, go to RESP.
  - Counter reaches TIMEOUT_CYCLE with no ready: drop other_sel_out, go to ERR.
  - Bus change check (priority over ready): if psel=0, the transfer is aborted. Drop other_sel_out, go to IDLE, no response.
  - If addr, write, prot or strb differ from the latched values, or wdata differs on a write: drop other_sel_out, go to ERR.
- RESP:
  - Drive apb_ready_out=1 for exactly one cycle, with apb_rdata_out set to the captured data and apb_slverr_out set to the captured error.
  - Next edge: go to IDLE; ready, slverr and rdata return to 0.
- ERR:
  - Drive apb_ready_out=1, apb_slverr_out=1, apb_rdata_out=0 for one cycle, then go to IDLE.
- Latency:
  - Setup edge to other_sel_out: 1 cycle.
  - Backend ready to PREADY: 1 cycle.
  - Minimum APB transfer is 3 cycles (setup + 2 access cycles, i.e. 1 wait state).
  - Decode or protection errors complete in 2 cycles (setup + 1 access).
- The counter is $clog2(TIMEOUT_CYCLE+1) bits wide and clears on entry to REQ. TIMEOUT_CYCLE cycles of no-ready produce ERR. A ready arriving on the same edge that reaches the timeout wins.
- Back-to-back transfers: a setup phase sampled in the cycle after RESP or ERR is accepted normally (IDLE is entered that cycle).
- Window arithmetic is done at APB_ADDR_WIDTH+1 bits so BASE_ADDR+ADDR_RANGE never wraps.

Test Plan:
- Write at addr BASE+0x10, wdata 0xA5A5_5A5A, strb 0xF; backend ready on the first REQ cycle -> other_sel_out high 1 cycle with offset 0x10; PREADY in cycle 3; PSLVERR=0.
- Read at BASE+0x4; backend returns 0x1234_5678 after 2 wait cycles -> PRDATA=0x1234_5678 with PREADY on the following cycle; other_strb_out=0 throughout.
- Read at BASE+ADDR_RANGE (out of window) -> backend never selected; PREADY=1 and PSLVERR=1 in the first access cycle; PRDATA=0.
- Backend holds other_ready_in=0 -> after 6 REQ cycles, other_sel_out drops; PREADY=1, PSLVERR=1.
- SECURE_ONLY=1, prot=3'b010 write -> PSLVERR=1 and no backend request. Separately, changing PADDR during the access phase -> ERR response.
- Assert apb_rstn_in low in REQ -> all outputs 0 immediately. After release, a new read completes normally in 3 cycles.
